serdes_lane_sequencer: RTL

Pixel-clock-domain controller that produces the four 10-bit lane words consumed by the four-lane 10:1 DDR serializer. It brings the link up with a fixed training pattern, then streams 40-bit words from an upstream source over a valid/ready handshake. It inserts an idle control word whenever the source underruns, and can retrain on request. It sits directly in front of the serializer and is the only driver of its four parallel inputs.

---
 rtl/serdes_lane_sequencer_pkg.sv | 34 +++
 rtl/serdes_lane_sequencer_if.sv | 10 +
 rtl/serdes_lane_sequencer_prbs7_gen.sv | 30 +++
 rtl/serdes_lane_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/serdes_lane_sequencer_pkg.sv
// Shared types and constants for the SERDES lane sequencer.
// The PRBS7 taps, the seed and the 10-bit stepping helper are only used
// when the design is built with SERDES_PRBS_EN defined.
package serdes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2
  } lane_state_e;

  localparam logic [9:0] DEF_IDLE_WORD  = 10'h354;
  localparam logic [9:0] DEF_TRAIN_WORD = 10'h01F;

  // x^7 + x^6 + 1: feedback is the XOR of state bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Ten serial PRBS7 steps; returns {next_state, word}, first bit in word[0]
  function automatic logic [16:0] prbs7_step10(input logic [6:0] seed);
    logic [6:0] s;
    logic [9:0] w;
    logic       b;
    s = seed;
    w = 10'd0;
    for (int i = 0; i < 10; i++) begin
      b    = ^(s & PRBS7_TAPS);
      w[i] = b;
      s    = {s[5:0], b};
    end
    return {s, w};
  endfunction

endpackage

// File: rtl/serdes_lane_sequencer_if.sv
// Source-side valid/ready handshake feeding the lane sequencer.
// Lane k of s_data is s_data[10k+9:10k].
interface serdes_lane_sequencer_if;
  logic [39:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/serdes_lane_sequencer_prbs7_gen.sv
// PRBS7 (x^7+x^6+1) generator producing ten bits per clock, first bit in
// word[0]. Only instantiated when SERDES_PRBS_EN is defined.
module prbs7_gen
  import serdes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  output logic [9:0] word
);

  logic [6:0]  lfsr_r;
  logic [16:0] step_s;

  assign step_s = prbs7_step10(lfsr_r);
  assign word   = step_s[9:0];

  // LFSR state: reseed on reset/load, step ten bits when the word is consumed
  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_r <= PRBS7_SEED;
    end else if (advance) begin
      lfsr_r <= step_s[16:10];
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

endmodule

// File: rtl/serdes_lane_sequencer.sv
// Lane sequencer in front of the four-lane 10:1 serializer: idles in OFF,
// sends a TRAIN_WORDS training burst, then streams source words and fills
// underruns with IDLE_WORD. Lane words lag the state by one cycle.
// Optional macro SERDES_PRBS_EN adds prbs_mode and a PRBS7 lane pattern.
module serdes_lane_sequencer
  import serdes_ctrl_pkg::*;
#(
  parameter int unsigned TRAIN_WORDS = 64,
  parameter logic [9:0]  IDLE_WORD   = DEF_IDLE_WORD,
  parameter logic [9:0]  TRAIN_WORD  = DEF_TRAIN_WORD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    train_req,
`ifdef SERDES_PRBS_EN
  input  logic                    prbs_mode,
`endif
  serdes_lane_sequencer_if.slave  src,
  output logic [9:0]              datain_0,
  output logic [9:0]              datain_1,
  output logic [9:0]              datain_2,
  output logic [9:0]              datain_3,
  output logic                    link_up,
  output logic [1:0]              state,
  output logic [15:0]             underrun_cnt
);

  localparam int             CW       = $clog2(TRAIN_WORDS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TRAIN_WORDS - 32'd1);

  lane_state_e      state_r;
  lane_state_e      cur_state_s;
  logic [CW-1:0]    cnt_r;
  logic [3:0][9:0]  lane_r;
  logic             link_up_r;
  logic [15:0]      underrun_r;
  logic             ready_s;
  logic             xfer_s;
  logic             underrun_s;

`ifdef SERDES_PRBS_EN
  logic             prbs_active_s;
  logic             prbs_load_s;
  logic [9:0]       prbs_word_s;
`endif

  // Decode the state register; the spare encoding behaves as OFF
  always_comb begin
    cur_state_s = ST_OFF;
    case (state_r)
      ST_TRAIN: cur_state_s = ST_TRAIN;
      ST_DATA:  cur_state_s = ST_DATA;
      default:  cur_state_s = ST_OFF;
    endcase
  end

`ifdef SERDES_PRBS_EN
  assign prbs_active_s = (cur_state_s == ST_DATA) && prbs_mode;
  // Reseed on the TRAIN->DATA transition so every DATA entry starts at the seed
  assign prbs_load_s   = enable && !train_req && (cur_state_s == ST_TRAIN) &&
                         (cnt_r == CNT_LAST);
  assign ready_s       = (cur_state_s == ST_DATA) && enable && !train_req && !prbs_mode;

  prbs7_gen u_prbs7_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (prbs_load_s),
    .advance (prbs_active_s),
    .word    (prbs_word_s)
  );
`else
  assign ready_s       = (cur_state_s == ST_DATA) && enable && !train_req;
`endif

  assign xfer_s     = ready_s && src.s_valid;
  assign underrun_s = ready_s && !src.s_valid;

  // Sequencer FSM with its registered lane words, link flag and underrun count
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_OFF;
      cnt_r      <= '0;
      lane_r     <= {4{IDLE_WORD}};
      link_up_r  <= 1'b0;
      underrun_r <= 16'd0;
    end else begin
      case (cur_state_s)
        ST_TRAIN: lane_r <= {4{TRAIN_WORD}};
        ST_DATA: begin
          if (xfer_s) begin
            lane_r <= src.s_data;
`ifdef SERDES_PRBS_EN
          end else if (prbs_active_s) begin
            lane_r <= {4{prbs_word_s}};
`endif
          end else begin
            lane_r <= {4{IDLE_WORD}};
          end
        end
        default: lane_r <= {4{IDLE_WORD}};
      endcase

      if (underrun_s && (underrun_r != 16'hFFFF)) begin
        underrun_r <= underrun_r + 16'd1;
      end

      if (!enable) begin
        state_r   <= ST_OFF;
        cnt_r     <= '0;
        link_up_r <= 1'b0;
      end else if (train_req && (cur_state_s != ST_OFF)) begin
        state_r   <= ST_TRAIN;
        cnt_r     <= '0;
        link_up_r <= 1'b0;
        if (cur_state_s == ST_DATA) begin
          underrun_r <= 16'd0;
        end
      end else begin
        case (cur_state_s)
          ST_OFF: begin
            state_r   <= ST_TRAIN;
            cnt_r     <= '0;
            link_up_r <= 1'b0;
          end
          ST_TRAIN: begin
            if (cnt_r == CNT_LAST) begin
              state_r   <= ST_DATA;
              cnt_r     <= '0;
              link_up_r <= 1'b1;
            end else begin
              state_r   <= ST_TRAIN;
              cnt_r     <= cnt_r + 1'b1;
              link_up_r <= 1'b0;
            end
          end
          ST_DATA: begin
            state_r   <= ST_DATA;
            link_up_r <= 1'b1;
          end
          default: begin
            state_r   <= ST_OFF;
            cnt_r     <= '0;
            link_up_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign src.s_ready  = ready_s;
  assign datain_0     = lane_r[0];
  assign datain_1     = lane_r[1];
  assign datain_2     = lane_r[2];
  assign datain_3     = lane_r[3];
  assign link_up      = link_up_r;
  assign state        = state_r;
  assign underrun_cnt = underrun_r;

endmodule
